// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the MEM stage of the pipelined ARM datapath.
// Byte-addressed big-endian RAM with programmable wait states, a busy/done
// handshake and misaligned word detection.
//
// Ports:
//   CLK        clock, all state updates on rising edge
//   CLR        asynchronous active-low reset
//   m_enable   request valid, sampled only while idle
//   m_rw       1 = store, 0 = load
//   m_size     1 = byte, 0 = 32-bit word
//   Address    byte address, low log2(DEPTH) bits used
//   DataIn     store data (byte store uses DataIn[7:0])
//   DataOut    registered load result, held until the next successful load
//   busy       request in flight
//   done       one-cycle completion pulse
//   misaligned word access with Address[1:0] != 0, valid with done
module data_mem_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        m_enable,
  input  logic        m_rw,
  input  logic        m_size,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  // Not reset so benches can preload it hierarchically.
  logic [7:0] Mem [0:DEPTH-1];

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rw_q, rw_d;
  logic          size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mis_q, mis_d;

  logic          word_mis;
  logic          mem_we;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   rd_word;
  logic          unused_addr;

  assign unused_addr = ^Address[31:AW];

  assign word_mis = !size_q && (addr_q[1:0] != 2'b00);

  // Byte lanes only matter for aligned words, so they never carry out of the
  // low two bits and an aligned word can never wrap.
  assign a0 = addr_q;
  assign a1 = {addr_q[AW-1:2], 2'd1};
  assign a2 = {addr_q[AW-1:2], 2'd2};
  assign a3 = {addr_q[AW-1:2], 2'd3};

  assign rd_word = {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};
  assign mem_we  = (state_q == StAccess) && rw_q && !word_mis;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m_enable) begin
          addr_d  = Address[AW-1:0];
          rw_d    = m_rw;
          size_d  = m_size;
          wdata_d = DataIn;
          busy_d  = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = StAccess;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        mis_d   = word_mis;
        if (!rw_q && !word_mis) begin
          dout_d = size_q ? {24'h0, Mem[a0]} : rd_word;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= 1'b0;
      wdata_q <= 32'h0;
      dout_q  <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  // Reset forces state_q to StIdle at once, so an aborted request never writes.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      if (size_q) begin
        Mem[a0] <= wdata_q[7:0];
      end else begin
        Mem[a0] <= wdata_q[31:24];
        Mem[a1] <= wdata_q[23:16];
        Mem[a2] <= wdata_q[15:8];
        Mem[a3] <= wdata_q[7:0];
      end
    end
  end

  assign DataOut    = dout_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: one instance with two wait states,
// one with none for back-to-back throughput.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        en, rw, sz;
  logic [31:0] addr, din, dout;
  logic        busy, done, mis;

  logic        en0, rw0, sz0;
  logic [31:0] addr0, din0, dout0;
  logic        busy0, done0, mis0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [0:255];
  logic [31:0] ref_dout;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .CLK(clk), .CLR(clr), .m_enable(en), .m_rw(rw), .m_size(sz),
    .Address(addr), .DataIn(din), .DataOut(dout), .busy(busy), .done(done),
    .misaligned(mis)
  );

  data_mem_ctrl #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .CLR(clr), .m_enable(en0), .m_rw(rw0), .m_size(sz0),
    .Address(addr0), .DataIn(din0), .DataOut(dout0), .busy(busy0), .done(done0),
    .misaligned(mis0)
  );

  // Reference model: big-endian byte RAM, address modulo 256.
  task automatic model(input logic w, input logic byte_op, input logic [31:0] a,
                       input logic [31:0] d, output logic exp_mis);
    int i;
    i = int'(a % 256);
    exp_mis = !byte_op && (i % 4 != 0);
    if (exp_mis) return;
    if (w) begin
      if (byte_op) ref_mem[i] = d[7:0];
      else begin
        ref_mem[i]   = d[31:24];
        ref_mem[i+1] = d[23:16];
        ref_mem[i+2] = d[15:8];
        ref_mem[i+3] = d[7:0];
      end
    end else begin
      if (byte_op) ref_dout = {24'h0, ref_mem[i]};
      else ref_dout = {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    dut.Mem[i] = v;
    ref_mem[i] = v;
  endtask

  // Present a request and return #1 after the accepting edge; inputs are then
  // scrambled to show they are ignored while busy.
  task automatic drive_req(input logic w, input logic byte_op, input logic [31:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; rw = w; sz = byte_op; addr = a; din = d;
    @(posedge clk);
    #1;
    en = 1'b0; rw = 1'($urandom); sz = 1'($urandom); addr = $urandom; din = $urandom;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 20);
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done: no done within %0d edges", edges);
    end
  endtask

  task automatic run_op(input string name, input logic w, input logic byte_op,
                        input logic [31:0] a, input logic [31:0] d);
    int   edges;
    logic exp_mis;
    model(w, byte_op, a, d, exp_mis);
    drive_req(w, byte_op, a, d);
    wait_done(edges);
    checks++;
    if (edges !== 3) begin
      errors++; $display("FAIL %s latency: got %0d edges, want 3", name, edges);
    end
    checks++;
    if (mis !== exp_mis) begin
      errors++; $display("FAIL %s misaligned: got %b want %b", name, mis, exp_mis);
    end
    checks++;
    if (dout !== ref_dout) begin
      errors++; $display("FAIL %s DataOut: got %h want %h", name, dout, ref_dout);
    end
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (dut.Mem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL %s Mem[%0d]: got %h want %h", name, i, dut.Mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, mis, dout} !== 35'h0) begin
      errors++; $display("FAIL reset_init: got %b%b%b %h want 0", busy, done, mis, dout);
    end
    @(negedge clk);
    clr = 1'b1;
    set_byte(8, 8'h11); set_byte(9, 8'h22); set_byte(10, 8'h33); set_byte(11, 8'h44);
    drive_req(1'b1, 1'b0, 32'd8, 32'hDEADBEEF);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy_before: got %b want 1", busy);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if ({busy, done, mis, dout} !== 35'h0) begin
      errors++; $display("FAIL reset_async: got %b%b%b %h want 0", busy, done, mis, dout);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    ref_dout = 32'h0;
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
      end
    end
    check_mem("reset_mem");
  endtask

  task automatic test_word();
    run_op("word_store", 1'b1, 1'b0, 32'd4, 32'h12345678);
    checks++;
    if ({dut.Mem[4], dut.Mem[5], dut.Mem[6], dut.Mem[7]} !== 32'h12345678) begin
      errors++;
      $display("FAIL word_store_bytes: got %h%h%h%h want 12345678",
               dut.Mem[4], dut.Mem[5], dut.Mem[6], dut.Mem[7]);
    end
    run_op("word_load", 1'b0, 1'b0, 32'd4, 32'h0);
    checks++;
    if (dout !== 32'h12345678) begin
      errors++; $display("FAIL word_load_const: got %h want 12345678", dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got %b want 0", done);
    end
  endtask

  task automatic test_byte();
    for (int i = 0; i < 256; i++) set_byte(i, 8'h00);
    run_op("strb", 1'b1, 1'b1, 32'd3, 32'h000000A5);
    run_op("ldr_after_strb", 1'b0, 1'b0, 32'd0, 32'h0);
    checks++;
    if (dout !== 32'h000000A5) begin
      errors++; $display("FAIL ldr_after_strb_const: got %h want 000000a5", dout);
    end
    run_op("ldrb", 1'b0, 1'b1, 32'd3, 32'h0);
    checks++;
    if (dout !== 32'h000000A5) begin
      errors++; $display("FAIL ldrb_const: got %h want 000000a5", dout);
    end
  endtask

  task automatic test_misaligned();
    run_op("mis_load", 1'b0, 1'b0, 32'd6, 32'h0);
    checks++;
    if (done !== 1'b1 || mis !== 1'b1 || dout !== 32'h000000A5) begin
      errors++;
      $display("FAIL mis_load_const: got done=%b mis=%b dout=%h want 1 1 000000a5",
               done, mis, dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mis !== 1'b0) begin
      errors++; $display("FAIL mis_clear: got %b want 0", mis);
    end
    run_op("mis_store", 1'b1, 1'b0, 32'd2, 32'hCAFEF00D);
    check_mem("mis_mem");
  endtask

  task automatic test_wrap();
    run_op("wrap_strb", 1'b1, 1'b1, 32'h00000105, 32'h00000077);
    checks++;
    if (dut.Mem[5] !== 8'h77) begin
      errors++; $display("FAIL wrap_mem5: got %h want 77", dut.Mem[5]);
    end
    run_op("last_word_store", 1'b1, 1'b0, 32'd252, 32'h89ABCDEF);
    run_op("last_word_load", 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0);
  endtask

  task automatic test_random();
    logic        w, b;
    logic [31:0] a, d;
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom);
      b = 1'($urandom);
      a = $urandom;
      d = $urandom;
      if (!b && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op("random", w, b, a, d);
    end
    check_mem("random_mem");
  endtask

  task automatic test_back_to_back();
    logic exp_done, exp_busy;
    dut0.Mem[0] = 8'h01; dut0.Mem[1] = 8'h02; dut0.Mem[2] = 8'h03; dut0.Mem[3] = 8'h04;
    dut0.Mem[4] = 8'hA0; dut0.Mem[5] = 8'hB0; dut0.Mem[6] = 8'hC0; dut0.Mem[7] = 8'hD0;
    @(negedge clk);
    en0 = 1'b1; rw0 = 1'b0; sz0 = 1'b0; addr0 = 32'd0; din0 = 32'h0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      #1;
      exp_done = (e == 1) || (e == 3);
      exp_busy = (e <= 3) && !exp_done;
      checks++;
      if (done0 !== exp_done || busy0 !== exp_busy) begin
        errors++;
        $display("FAIL b2b edge %0d: got done=%b busy=%b want %b %b",
                 e, done0, busy0, exp_done, exp_busy);
      end
      if (e == 1) begin
        checks++;
        if (dout0 !== 32'h01020304) begin
          errors++; $display("FAIL b2b_load0: got %h want 01020304", dout0);
        end
        addr0 = 32'd4;
      end
      if (e == 3) begin
        checks++;
        if (dout0 !== 32'hA0B0C0D0) begin
          errors++; $display("FAIL b2b_load1: got %h want a0b0c0d0", dout0);
        end
        en0 = 1'b0;
      end
    end
  endtask

  initial begin
    clr = 1'b0;
    en = 1'b0; rw = 1'b0; sz = 1'b0; addr = 32'h0; din = 32'h0;
    en0 = 1'b0; rw0 = 1'b0; sz0 = 1'b0; addr0 = 32'h0; din0 = 32'h0;
    ref_dout = 32'h0;
    #1;
    for (int i = 0; i < 256; i++) begin
      set_byte(i, 8'($urandom));
      dut0.Mem[i] = 8'h00;
    end
    #10;
    test_reset();
    test_word();
    test_byte();
    test_misaligned();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
